// File: rtl/multi_gate_pipe_v.sv
// multi_gate_pipe_v: two-stage valid/ready pipeline that reduces N_INPUTS
// operands lane-by-lane with one of eight selectable bitwise functions and
// counts the results handed downstream.
module multi_gate_pipe_v #(
    parameter int N_INPUTS = 3,
    parameter int WIDTH    = 4,
    parameter int COUNT_W  = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [N_INPUTS*WIDTH-1:0]    i_data,
    input  logic [2:0]                   i_code,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [WIDTH-1:0]             o_f,
    output logic [COUNT_W-1:0]           o_count
);

    localparam int DW = N_INPUTS * WIDTH;

    localparam logic [2:0] CODE_XOR  = 3'b000;
    localparam logic [2:0] CODE_NAND = 3'b001;
    localparam logic [2:0] CODE_NOR  = 3'b010;
    localparam logic [2:0] CODE_XNOR = 3'b011;
    localparam logic [2:0] CODE_AND  = 3'b100;
    localparam logic [2:0] CODE_OR   = 3'b101;
    localparam logic [2:0] CODE_MAJ  = 3'b110;
    localparam logic [2:0] CODE_EQ   = 3'b111;

    // Lane-wise reduction of all operands; MAJ is a strict majority so a tie
    // yields 0, EQ is true when the lane is all-ones or all-zeros.
    function automatic logic [WIDTH-1:0] reduce_f(input logic [DW-1:0] data,
                                                  input logic [2:0]    code);
        logic [WIDTH-1:0] xor_v;
        logic [WIDTH-1:0] and_v;
        logic [WIDTH-1:0] or_v;
        logic [WIDTH-1:0] maj_v;
        logic [WIDTH-1:0] res_v;
        int               ones;
        xor_v = data[WIDTH-1:0];
        and_v = data[WIDTH-1:0];
        or_v  = data[WIDTH-1:0];
        maj_v = {WIDTH{1'b0}};
        for (int k = 1; k < N_INPUTS; k++) begin
            xor_v = xor_v ^ data[k*WIDTH +: WIDTH];
            and_v = and_v & data[k*WIDTH +: WIDTH];
            or_v  = or_v  | data[k*WIDTH +: WIDTH];
        end
        for (int j = 0; j < WIDTH; j++) begin
            ones = 0;
            for (int k = 0; k < N_INPUTS; k++) begin
                ones = ones + int'(data[k*WIDTH + j]);
            end
            maj_v[j] = (ones > (N_INPUTS / 2));
        end
        case (code)
            CODE_XOR:  res_v = xor_v;
            CODE_NAND: res_v = ~and_v;
            CODE_NOR:  res_v = ~or_v;
            CODE_XNOR: res_v = ~xor_v;
            CODE_AND:  res_v = and_v;
            CODE_OR:   res_v = or_v;
            CODE_MAJ:  res_v = maj_v;
            CODE_EQ:   res_v = and_v | ~or_v;
            default:   res_v = {WIDTH{1'b0}};
        endcase
        return res_v;
    endfunction

    logic              s1_valid_r;
    logic [DW-1:0]     s1_data_r;
    logic [2:0]        s1_code_r;
    logic              s2_free_s;
    logic [WIDTH-1:0]  f_s;

    // Handshake steering and stage-2 function evaluation from the S1 holding register.
    always_comb begin
        s2_free_s = 1'b0;
        o_ready   = 1'b0;
        f_s       = {WIDTH{1'b0}};
        s2_free_s = !o_valid || i_ready;
        o_ready   = !s1_valid_r || s2_free_s;
        f_s       = reduce_f(s1_data_r, s1_code_r);
    end

    // Stage 1: capture the incoming beat whenever the stage can move forward.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {DW{1'b0}};
            s1_code_r  <= 3'b000;
        end else if (o_ready) begin
            s1_valid_r <= i_valid;
            if (i_valid) begin
                s1_data_r <= i_data;
                s1_code_r <= i_code;
            end
        end
    end

    // Stage 2: register the result; o_f keeps its last value when a bubble moves in.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_f     <= {WIDTH{1'b0}};
        end else if (s2_free_s) begin
            o_valid <= s1_valid_r;
            if (s1_valid_r) begin
                o_f <= f_s;
            end
        end
    end

    // Delivered-result counter, wraps naturally at 2^COUNT_W.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_count <= {COUNT_W{1'b0}};
        end else if (o_valid && i_ready) begin
            o_count <= o_count + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
